ifu_align: RTL and testbench

- Instruction alignment buffer in the IFU, directly upstream of the instruction decompressor.
- Accepts in-order, word-aligned 32-bit fetch words and assembles a halfword-aligned 32-bit instruction window plus PC for the decompressor input.
- Handles 16-bit instructions, 32-bit instructions straddling word boundaries, and redirect (flush) to halfword-aligned targets.

---
 rtl/ifu_align.sv | 83 ++++++++
 tb/tb_ifu_align.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ifu_align.sv
// rtl/ifu_align.sv - instruction alignment buffer: word-aligned fetch words in, halfword-aligned instructions out
// Four-halfword queue feeding the decompressor; the head decides 16- vs 32-bit length.
module ifu_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [30:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [30:0] instr_pc
);

  logic [15:0] hw_q [4];
  logic [15:0] hw_d [4];
  logic [15:0] sh   [4];
  logic [2:0]  count_q, count_d;
  logic [30:0] pc_q, pc_d;
  logic        drop_low_q, drop_low_d;
  logic        is32, do_push, do_pop;
  logic [2:0]  pop_n, rem, rem_p1;

  assign is32        = (hw_q[0][1:0] == 2'b11);
  assign fetch_ready = (count_q <= 3'd2);
  assign instr_valid = (count_q >= 3'd2) || (count_q == 3'd1 && !is32);
  assign instr_data  = (count_q >= 3'd2) ? {hw_q[1], hw_q[0]} :
                       (count_q == 3'd1) ? {16'h0, hw_q[0]} : 32'h0;
  assign instr_pc    = pc_q;
  assign do_push     = fetch_valid && fetch_ready && !flush;
  assign do_pop      = instr_valid && instr_ready && !flush;

  always_comb begin
    pop_n = 3'd0;
    if (do_pop) pop_n = is32 ? 3'd2 : 3'd1;
    case (pop_n)
      3'd1:    sh = '{hw_q[1], hw_q[2], hw_q[3], 16'h0};
      3'd2:    sh = '{hw_q[2], hw_q[3], 16'h0, 16'h0};
      default: sh = hw_q;
    endcase
    rem    = count_q - pop_n;
    rem_p1 = rem + 3'd1;
    // Pushed halfwords land right after whatever survives the pop.
    for (int i = 0; i < 4; i++) begin
      hw_d[i] = sh[i];
      if (do_push) begin
        if (drop_low_q) begin
          if (3'(i) == rem) hw_d[i] = fetch_data[31:16];
        end else begin
          if (3'(i) == rem)         hw_d[i] = fetch_data[15:0];
          else if (3'(i) == rem_p1) hw_d[i] = fetch_data[31:16];
        end
      end
    end
    count_d    = rem + (do_push ? (drop_low_q ? 3'd1 : 3'd2) : 3'd0);
    pc_d       = pc_q + {29'b0, pop_n[1:0]};
    drop_low_d = drop_low_q && !do_push;
    if (flush) begin
      count_d    = 3'd0;
      pc_d       = flush_pc;
      drop_low_d = flush_pc[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) hw_q[i] <= 16'h0;
      count_q    <= 3'd0;
      pc_q       <= RESET_PC[31:1];
      drop_low_q <= RESET_PC[1];
    end else begin
      for (int i = 0; i < 4; i++) hw_q[i] <= hw_d[i];
      count_q    <= count_d;
      pc_q       <= pc_d;
      drop_low_q <= drop_low_d;
    end
  end

endmodule

// File: tb/tb_ifu_align.sv
// tb/tb_ifu_align.sv - scoreboard bench for ifu_align
module tb_ifu_align;

  logic        clk = 1'b0;
  logic        reset_n, flush, fetch_valid, fetch_ready, instr_valid, instr_ready;
  logic [30:0] flush_pc, instr_pc;
  logic [31:0] fetch_data, instr_data;

  ifu_align #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] pc;
    logic [31:0] data;
    logic [31:0] mask;
    int          sz;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mhw[$];
  logic [30:0] mpc;
  logic        mdrop;
  int          mcount;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset(input logic [30:0] pc, input logic drop);
    exp_q.delete();
    mhw.delete();
    mcount = 0;
    mpc    = pc;
    mdrop  = drop;
  endtask

  // Bench-side decoder over the whole accepted halfword stream.
  task automatic model_push(input logic [31:0] w);
    exp_t e;
    if (!mdrop) begin
      mhw.push_back(w[15:0]);
      mcount++;
    end
    mhw.push_back(w[31:16]);
    mcount++;
    mdrop = 1'b0;
    forever begin
      if (mhw.size() == 0) break;
      if (mhw[0][1:0] == 2'b11) begin
        if (mhw.size() < 2) break;
        e.pc = mpc; e.data = {mhw[1], mhw[0]}; e.mask = 32'hFFFF_FFFF; e.sz = 2;
        void'(mhw.pop_front());
        void'(mhw.pop_front());
        mpc = mpc + 31'd2;
      end else begin
        e.pc = mpc; e.data = {16'h0, mhw[0]}; e.mask = 32'h0000_FFFF; e.sz = 1;
        void'(mhw.pop_front());
        mpc = mpc + 31'd1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input logic fv, input logic [31:0] fd, input logic ir,
                      input logic fl, input logic [30:0] fpc, input logic rn);
    exp_t e;
    logic accept;
    fetch_valid = fv; fetch_data = fd; instr_ready = ir;
    flush = fl; flush_pc = fpc; reset_n = rn;
    @(negedge clk);
    check("valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
    check("fready", {31'b0, fetch_ready}, {31'b0, mcount <= 2});
    if (instr_valid && exp_q.size() != 0) begin
      check("pc", {1'b0, instr_pc}, {1'b0, exp_q[0].pc});
      check("data", instr_data & exp_q[0].mask, exp_q[0].data);
    end
    accept = fv && (mcount <= 2);
    if (!rn) begin
      model_reset(31'h0, 1'b0);
    end else if (fl) begin
      model_reset(fpc, fpc[0]);
    end else begin
      if (instr_valid && ir && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        mcount -= e.sz;
      end
      if (accept) model_push(fd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ir);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, ir, 1'b0, 31'h0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; flush_pc = 31'h0;
    fetch_valid = 1'b0; fetch_data = 32'h0; instr_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_fready", {31'b0, fetch_ready}, 32'h1);
    check("rst_pc", {1'b0, instr_pc}, 32'h0);
    check("rst_data", instr_data, 32'h0);
    model_reset(31'h0, 1'b0);

    step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 31'h0, 1'b1);
    step(1'b1, 32'h0010_0093, 1'b1, 1'b0, 31'h0, 1'b1);
    idle(3, 1'b1);

    step(1'b1, 32'h4501_4501, 1'b1, 1'b0, 31'h0, 1'b1);
    idle(3, 1'b1);

    step(1'b1, 32'h0013_4501, 1'b1, 1'b0, 31'h0, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 31'h0, 1'b1);
    idle(3, 1'b1);

    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 31'h0000_0803, 1'b1);
    step(1'b1, 32'h0013_4501, 1'b1, 1'b0, 31'h0, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 32'h00B0_0513, 1'b1, 1'b0, 31'h0, 1'b1);
    idle(3, 1'b1);

    for (int k = 0; k < 6; k++) step(1'b1, $urandom, 1'b0, 1'b0, 31'h0, 1'b1);
    idle(10, 1'b1);

    step(1'b0, 32'h0, 1'b1, 1'b1, 31'h7FFF_FFFE, 1'b1);
    step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 31'h0, 1'b1);
    step(1'b1, 32'h4501_4501, 1'b1, 1'b0, 31'h0, 1'b1);
    idle(4, 1'b1);

    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), 31'($urandom),
           ($urandom_range(0, 63) != 0));
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1, 1'b1);
    check("drain", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
